// File: rtl/nibble_packer_pkg.sv
// Shared defaults and types for the nibble packer and its output word FIFO.
package nibble_pkg;

  localparam int NIB_W_DEF    = 4;
  localparam int NIBS_DEF     = 4;
  localparam int W_DEF        = NIB_W_DEF * NIBS_DEF;
  localparam int CNT_BITS_DEF = $clog2(NIBS_DEF + 1);

  typedef enum logic [0:0] {
    ACC_EMPTY,
    ACC_PART
  } acc_state_e;

  typedef struct packed {
    logic [W_DEF-1:0]        word;
    logic [CNT_BITS_DEF-1:0] cnt;
  } nib_word_t;

endpackage

// File: rtl/nibble_packer_fifo.sv
// Small synchronous word FIFO; head entry is shown combinationally and reads as zero when empty.
module nibble_packer_fifo
  import nibble_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = nib_word_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  entry_t           data_i,
  input  logic             pop_i,
  output entry_t           data_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Guard both sides so a stray request can never corrupt the count.
  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/nibble_packer.sv
// Packs a nibble stream into LSB-first words and queues them for a valid/ready sink.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int  NIB_W      = NIB_W_DEF,
  parameter int  NIBS       = NIBS_DEF,
  parameter int  FIFO_DEPTH = 2,
  parameter int  CNT_W      = 16,
  localparam int W          = NIB_W * NIBS,
  localparam int CNT_BITS   = $clog2(NIBS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [NIB_W-1:0]    in_nib_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [W-1:0]        out_word_o,
  output logic [CNT_BITS-1:0] out_cnt_o,
  output logic [CNT_W-1:0]    words_sent_o
);

  localparam int IDX_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [W-1:0]        word;
    logic [CNT_BITS-1:0] cnt;
  } word_t;

  acc_state_e          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    wr_idx;
  logic [W-1:0]        acc_q;
  logic [W-1:0]        acc_wr;
  logic [CNT_W-1:0]    words_sent_q;
  logic [CNT_W-1:0]    words_sent_d;
  logic [FCNT_W-1:0]   fifo_count;
  logic                in_fire;
  logic                out_fire;
  logic                word_done;
  word_t               push_word;
  word_t               head_word;

  assign in_ready_o = (fifo_count < FCNT_W'(FIFO_DEPTH));
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_valid_o = (fifo_count != '0);
  assign out_fire   = out_valid_o && out_ready_i;

  // Everything written here is only consumed on in_fire, so idle X on in_nib/in_last stays contained.
  always_comb begin
    wr_idx         = (state_q == ACC_EMPTY) ? '0 : idx_q;
    acc_wr         = acc_q;
    acc_wr[wr_idx*NIB_W +: NIB_W] = in_nib_i;
    word_done      = in_fire && (in_last_i || (wr_idx == IDX_W'(NIBS - 1)));
    push_word.word = acc_wr;
    push_word.cnt  = CNT_BITS'(wr_idx) + CNT_BITS'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACC_EMPTY;
      idx_q   <= '0;
      acc_q   <= '0;
    end else if (in_fire) begin
      if (word_done) begin
        state_q <= ACC_EMPTY;
        idx_q   <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          ACC_EMPTY: idx_q <= IDX_W'(1);
          default:   idx_q <= idx_q + IDX_W'(1);
        endcase
        state_q <= ACC_PART;
        acc_q   <= acc_wr;
      end
    end
  end

  assign words_sent_d = out_fire ? words_sent_q + CNT_W'(1) : words_sent_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_sent_q <= '0;
    end else begin
      words_sent_q <= words_sent_d;
    end
  end

  nibble_packer_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (word_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (word_done),
    .data_i  (push_word),
    .pop_i   (out_fire),
    .data_o  (head_word),
    .count_o (fifo_count)
  );

  assign out_word_o   = head_word.word;
  assign out_cnt_o    = head_word.cnt;
  assign words_sent_o = words_sent_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Table-driven and scoreboard-checked bench for nibble_packer with a 4-bit words_sent counter.
module tb_nibble_packer;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [3:0]  inNib;
  logic        inLast;
  logic        outValid;
  logic        outReady;
  logic [15:0] outWord;
  logic [2:0]  outCnt;
  logic [3:0]  wordsSent;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  cnt;
  } expT;

  typedef struct {
    int          n;
    logic [3:0]  nib [4];
    bit          last;
    logic [15:0] expWord;
    logic [2:0]  expCnt;
  } vecT;

  expT sb[$];
  vecT vecs[5];

  nibble_packer #(
    .NIB_W      (4),
    .NIBS       (4),
    .FIFO_DEPTH (2),
    .CNT_W      (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .in_nib_i     (inNib),
    .in_last_i    (inLast),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .out_word_o   (outWord),
    .out_cnt_o    (outCnt),
    .words_sent_o (wordsSent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic expT mkExp(input logic [15:0] w, input logic [2:0] c);
    expT e;
    e.word = w;
    e.cnt  = c;
    return e;
  endfunction

  // Inputs change only just after posedge, so a negedge sample predicts the next edge's handshake.
  always @(negedge clk) begin
    if (rstN && outValid && outReady) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sbUnexpected: got word %0h with nothing expected", outWord);
      end else begin
        expT e;
        e = sb.pop_front();
        checkOutput("sbWord", outWord, e.word);
        checkOutput("sbCnt", outCnt, e.cnt);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] nib, input logic last);
    bit done;
    done    = 0;
    inValid = 1'b1;
    inNib   = nib;
    inLast  = last;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (inReady) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL acceptTimeout: nibble %0h never accepted", nib);
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rstN     = 1'b0;
    inValid  = 1'b0;
    inLast   = 1'b0;
    outReady = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    checkOutput("rstValid", outValid, 0);
    checkOutput("rstReady", inReady, 1);
    checkOutput("rstWord", outWord, 0);
    checkOutput("rstCnt", outCnt, 0);
    checkOutput("rstSent", wordsSent, 0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !outValid) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL drainTimeout: %0d words still expected", sb.size());
    end
  endtask

  task automatic setVec(input int i, input int n, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d, input bit last,
                        input logic [15:0] w, input logic [2:0] cnt);
    vecs[i].n       = n;
    vecs[i].nib[0]  = a;
    vecs[i].nib[1]  = b;
    vecs[i].nib[2]  = c;
    vecs[i].nib[3]  = d;
    vecs[i].last    = last;
    vecs[i].expWord = w;
    vecs[i].expCnt  = cnt;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    int nibVal;
    bit rdy;

    rstN     = 1'b1;
    inValid  = 1'b0;
    inNib    = 4'hx;
    inLast   = 1'bx;
    outReady = 1'b0;

    setVec(0, 4, 4'h1, 4'h2, 4'h3, 4'h4, 0, 16'h4321, 3'd4);
    setVec(1, 2, 4'hA, 4'hB, 4'h0, 4'h0, 1, 16'h00BA, 3'd2);
    setVec(2, 1, 4'h3, 4'h0, 4'h0, 4'h0, 1, 16'h0003, 3'd1);
    setVec(3, 3, 4'hF, 4'h0, 4'hE, 4'h0, 1, 16'h0E0F, 3'd3);
    setVec(4, 4, 4'h9, 4'h8, 4'h7, 4'h6, 1, 16'h6789, 3'd4);

    applyReset();

    // Word table: full words, partial flushes, single nibble, last on the NIBS-th nibble.
    outReady = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        applyStimulus(vecs[v].nib[k], (k == vecs[v].n - 1) ? vecs[v].last : 1'b0);
      end
      sb.push_back(mkExp(vecs[v].expWord, vecs[v].expCnt));
    end
    drain();
    checkOutput("tableSent", wordsSent, 5);

    // Asynchronous reset in the middle of a word.
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstValid", outValid, 0);
    checkOutput("midRstReady", inReady, 1);
    checkOutput("midRstSent", wordsSent, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'h5, 1'b0);
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    applyStimulus(4'h8, 1'b0);
    sb.push_back(mkExp(16'h8765, 3'd4));
    drain();

    // Back-to-back full word and its one-cycle latency.
    applyReset();
    outReady = 1'b1;
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    inValid = 1'b1;
    inNib   = 4'h4;
    inLast  = 1'b0;
    @(negedge clk);
    checkOutput("latPreValid", outValid, 0);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    sb.push_back(mkExp(16'h4321, 3'd4));
    @(negedge clk);
    checkOutput("latValid", outValid, 1);
    checkOutput("latWord", outWord, 16'h4321);
    checkOutput("latCnt", outCnt, 4);
    @(negedge clk);
    checkOutput("latSent", wordsSent, 1);
    drain();

    // Backpressure: fill the FIFO with two words while the sink stalls.
    applyReset();
    outReady = 1'b0;
    inValid  = 1'b1;
    inLast   = 1'b0;
    accepted = 0;
    nibVal   = 1;
    for (int c = 0; c < 40 && accepted < 8; c++) begin
      inNib = 4'(nibVal);
      @(negedge clk);
      rdy = inReady;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted++;
        nibVal++;
      end
    end
    checkOutput("fillAccepted", accepted, 8);
    sb.push_back(mkExp(16'h4321, 3'd4));
    sb.push_back(mkExp(16'h8765, 3'd4));
    inNib  = 4'h9;
    inLast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("fullReady", inReady, 0);
      checkOutput("fullValid", outValid, 1);
      checkOutput("fullHold", outWord, 16'h4321);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    rdy = 0;
    for (int c = 0; c < 20 && !rdy; c++) begin
      @(negedge clk);
      rdy = inReady;
    end
    checkOutput("resumeReady", rdy, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    sb.push_back(mkExp(16'h0009, 3'd1));
    drain();

    // Push and pop on the same edge with one word already queued.
    applyReset();
    outReady = 1'b0;
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h4, 1'b0);
    sb.push_back(mkExp(16'h4321, 3'd4));
    applyStimulus(4'hA, 1'b0);
    applyStimulus(4'hB, 1'b0);
    applyStimulus(4'hC, 1'b0);
    outReady = 1'b1;
    applyStimulus(4'hD, 1'b0);
    sb.push_back(mkExp(16'hDCBA, 3'd4));
    outReady = 1'b0;
    @(negedge clk);
    checkOutput("ppValid", outValid, 1);
    checkOutput("ppWord", outWord, 16'hDCBA);
    checkOutput("ppCnt", outCnt, 4);
    checkOutput("ppReady", inReady, 1);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    @(negedge clk);
    checkOutput("ppEmpty", outValid, 0);
    checkOutput("ppSent", wordsSent, 2);

    // 19 single-nibble words wrap the 4-bit handshake counter to 3.
    applyReset();
    outReady = 1'b1;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(4'(i), 1'b1);
      sb.push_back(mkExp({12'h000, 4'(i)}, 3'd1));
    end
    drain();
    checkOutput("wrapSent", wordsSent, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
